// File: rtl/uart_word_loader_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_word_loader_pkg                                                     |
// | Shared UART line defaults, frame geometry and FSM state encodings.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package uart_word_loader_pkg;

    localparam int CLK_FREQ       = 50_000_000;
    localparam int BAUD           = 115_200;
    localparam int WORD_BYTES     = 5;
    localparam int DATA_W         = 40;
    localparam int NUM_WORDS      = 540;
    localparam int ADDR_W         = 10;
    localparam int TIMEOUT_CYCLES = 100_000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } load_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_word_loader_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_rx_byte                                                             |
// | 8N1 oversampling byte receiver with 2-flop input synchroniser.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       areset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       byte_valid,
    output logic       frame_err
);
    import uart_word_loader_pkg::*;

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             sync1_q, sync2_q, prev_q;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (prev_q && !sync2_q) state_d = RX_START;
            end
            RX_START: begin
                // A start bit that is high again at its midpoint was a glitch
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = sync2_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = RX_STOP;
                    else               bit_d   = bit_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    valid_d = sync2_q;
                    ferr_d  = !sync2_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign data       = shift_q;
    assign byte_valid = valid_q;
    assign frame_err  = ferr_q;

endmodule
`default_nettype wire

// File: rtl/uart_word_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_word_loader                                                         |
// | Assembles LSB-first UART bytes into words and writes a frame to RAM.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module uart_word_loader #(
    parameter int CLK_FREQ       = uart_word_loader_pkg::CLK_FREQ,
    parameter int BAUD           = uart_word_loader_pkg::BAUD,
    parameter int WORD_BYTES     = uart_word_loader_pkg::WORD_BYTES,
    parameter int DATA_W         = uart_word_loader_pkg::DATA_W,
    parameter int NUM_WORDS      = uart_word_loader_pkg::NUM_WORDS,
    parameter int ADDR_W         = uart_word_loader_pkg::ADDR_W,
    parameter int TIMEOUT_CYCLES = uart_word_loader_pkg::TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              rx,
    input  logic              start,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    output logic              busy,
    output logic              done,
    output logic              frame_err,
    output logic              timeout
);
    import uart_word_loader_pkg::*;

    localparam int IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WORD_BYTES - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
    localparam logic [TO_W-1:0]   TO_M1     = TO_W'(TIMEOUT_CYCLES - 1);

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ferr;

    uart_rx_byte #(
        .CLKS_PER_BIT (clks_per_bit(CLK_FREQ, BAUD))
    ) u_rx (
        .clk        (clk),
        .areset     (areset),
        .rx         (rx),
        .data       (rx_data),
        .byte_valid (rx_valid),
        .frame_err  (rx_ferr)
    );

    load_state_e       state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [TO_W-1:0]   tcnt_q, tcnt_d;
    logic [ADDR_W-1:0] ram_address_q, ram_address_d;
    logic [DATA_W-1:0] ram_data_q, ram_data_d;
    logic              ram_wren_q, ram_wren_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            word_q        <= '0;
            addr_q        <= '0;
            tcnt_q        <= '0;
            ram_address_q <= '0;
            ram_data_q    <= '0;
            ram_wren_q    <= 1'b0;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            word_q        <= word_d;
            addr_q        <= addr_d;
            tcnt_q        <= tcnt_d;
            ram_address_q <= ram_address_d;
            ram_data_q    <= ram_data_d;
            ram_wren_q    <= ram_wren_d;
            done_q        <= done_d;
            timeout_q     <= timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        word_d        = word_q;
        addr_d        = addr_q;
        tcnt_d        = tcnt_q;
        ram_address_d = ram_address_q;
        ram_data_d    = ram_data_q;
        ram_wren_d    = 1'b0;
        done_d        = done_q;
        timeout_d     = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    addr_d  = '0;
                    idx_d   = '0;
                    tcnt_d  = '0;
                    done_d  = 1'b0;
                end
            end
            ST_LOAD: begin
                // Address advances the cycle after a write; the final word ends the frame
                if (ram_wren_q) begin
                    if (ram_address_q == LAST_ADDR) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
                if (rx_valid) begin
                    tcnt_d                = '0;
                    word_d[8*idx_q +: 8]  = rx_data;
                    if (idx_q == LAST_IDX) begin
                        idx_d         = '0;
                        ram_wren_d    = 1'b1;
                        ram_data_d    = word_d;
                        ram_address_d = addr_q;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else if (rx_ferr) begin
                    idx_d  = '0;
                    tcnt_d = '0;
                end else if (idx_q != '0) begin
                    if (tcnt_q == TO_M1) begin
                        idx_d     = '0;
                        tcnt_d    = '0;
                        timeout_d = 1'b1;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign ram_address = ram_address_q;
    assign ram_data    = ram_data_q;
    assign ram_wren    = ram_wren_q;
    assign busy        = (state_q == ST_LOAD);
    assign done        = done_q;
    assign frame_err   = rx_ferr;
    assign timeout     = timeout_q;

endmodule
`default_nettype wire
